// File: rtl/ov5640_dvp_tx.sv
// ============================================================================
// ov5640_dvp_tx
// ----------------------------------------------------------------------------
// Purpose:
//   OV5640-style DVP transmitter. It takes 16-bit RGB565 pixels from a
//   valid/ready stream with a start-of-frame flag and sends them as an 8-bit
//   DVP byte stream (high byte first, one byte per clk_50m cycle), framed by
//   dvp_vsync/dvp_href with parameterised blanking. It emulates a camera
//   sensor so the capture path can be exercised in loopback without a camera.
//
// Ports:
//   clk_50m     in   1   clock; all dvp_* outputs change on its rising edge
//   sys_rst     in   1   synchronous reset, active-high
//   tx_en       in   1   start/continue framing, looked at only at frame edges
//   pix_data    in  16   RGB565 pixel
//   pix_valid   in   1   pix_data is valid
//   pix_sof     in   1   pix_data is pixel (0,0) of a frame
//   pix_ready   out  1   pixel accepted when pix_valid & pix_ready
//   dvp_vsync   out  1   frame sync, active-high
//   dvp_href    out  1   line valid
//   dvp_data    out  8   byte data
//   frame_done  out  1   one-cycle pulse on the last cycle of the front porch
//   underrun    out  1   sticky: a pixel slot found no valid pixel
//   sync_err    out  1   sticky: SOF seen away from (0,0), or (0,0) lacked SOF
//   busy        out  1   framing in progress (state is not IDLE)
// ============================================================================
module ov5640_dvp_tx #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 64,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 4,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FRONT  = 2,
    parameter logic [15:0] FILL     = 16'h0000
) (
    input  logic        clk_50m,
    input  logic        sys_rst,
    input  logic        tx_en,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        underrun,
    output logic        sync_err,
    output logic        busy
);

    // Every line, including sync and porch lines, is LINE_LEN cycles long.
    localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam int unsigned HW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int unsigned VW = (V_TOTAL  > 1) ? $clog2(V_TOTAL)  : 1;

    // Counter values marking the ends of each region. vcnt counts lines from
    // the start of VSYNC, so the active lines follow the sync and back porch.
    localparam logic [HW-1:0] H_LAST       = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_ACT_LAST   = HW'(2 * H_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] V_BACK_LAST  = VW'(V_SYNC + V_BACK - 1);
    localparam logic [VW-1:0] V_ACT_FIRST  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_HBLANK,
        S_VFRONT
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;

    logic            vsync_q, href_q, frameDone_q;
    logic [7:0]      data_q, data_d;
    logic [7:0]      lowByte_q, lowByte_d;
    logic            underrun_q, underrun_d;
    logic            syncErr_q, syncErr_d;

    logic            lineEnd;
    logic            frameEnd;
    logic            clearSticky;
    logic            firstSlot;
    logic [HW-1:0]   hcntNext;
    logic [VW-1:0]   vcntNext;

    assign lineEnd   = (hcnt_q == H_LAST);
    assign firstSlot = (vcnt_q == V_ACT_FIRST) && (hcnt_q == '0);

    // Free-running position inside the frame: hcnt wraps at the end of each
    // line, vcnt wraps at the end of the last front-porch line.
    assign hcntNext = lineEnd ? '0 : hcnt_q + HW'(1);
    assign vcntNext = lineEnd ? ((vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1))
                              : vcnt_q;

    // Next-state logic. Region changes happen on line ends, except the
    // ACTIVE->HBLANK split which happens mid-line after the last byte.
    // tx_en is only examined in IDLE and on the final front-porch cycle, so
    // a frame in flight always completes.
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcntNext;
        vcnt_d      = vcntNext;
        frameEnd    = 1'b0;
        clearSticky = 1'b0;
        case (state_q)
            S_IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (tx_en) begin
                    state_d     = S_VSYNC;
                    clearSticky = 1'b1;
                end
            end
            S_VSYNC: begin
                if (lineEnd && (vcnt_q == V_SYNC_LAST)) begin
                    state_d = S_VBACK;
                end
            end
            S_VBACK: begin
                if (lineEnd && (vcnt_q == V_BACK_LAST)) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (hcnt_q == H_ACT_LAST) begin
                    state_d = S_HBLANK;
                end
            end
            S_HBLANK: begin
                if (lineEnd) begin
                    state_d = (vcnt_q == V_ACT_LAST) ? S_VFRONT : S_ACTIVE;
                end
            end
            S_VFRONT: begin
                if (lineEnd && (vcnt_q == V_LAST)) begin
                    frameEnd = 1'b1;
                    state_d  = tx_en ? S_VSYNC : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
        endcase
    end

    // Ready generation. Before the active region, non-SOF pixels are drained
    // so that the SOF pixel is waiting at the head for slot (0,0). In the
    // active region only the even (high-byte) cycle of each slot takes a pixel.
    always_comb begin
        pix_ready = 1'b0;
        case (state_q)
            S_VSYNC, S_VBACK: pix_ready = pix_valid & ~pix_sof;
            S_ACTIVE:         pix_ready = ~hcnt_q[0];
            default:          pix_ready = 1'b0;
        endcase
    end

    // Byte path and sticky flags. On the even cycle of a slot the high byte
    // goes out next and the low byte is parked; a missing pixel is replaced
    // by FILL so the line timing never stretches. An SOF mismatch at any slot
    // still transmits the pixel but flags sync_err.
    always_comb begin
        data_d     = 8'h00;
        lowByte_d  = lowByte_q;
        underrun_d = underrun_q;
        syncErr_d  = syncErr_q;
        if (clearSticky) begin
            underrun_d = 1'b0;
            syncErr_d  = 1'b0;
        end
        if (state_q == S_ACTIVE) begin
            if (!hcnt_q[0]) begin
                if (pix_valid) begin
                    data_d    = pix_data[15:8];
                    lowByte_d = pix_data[7:0];
                    if (pix_sof != firstSlot) begin
                        syncErr_d = 1'b1;
                    end
                end else begin
                    data_d     = FILL[15:8];
                    lowByte_d  = FILL[7:0];
                    underrun_d = 1'b1;
                end
            end else begin
                data_d = lowByte_q;
            end
        end
    end

    // State, counters and registered outputs. vsync/href are registered
    // copies of the state so they line up with dvp_data, which is itself one
    // cycle behind the slot that accepted the pixel.
    always_ff @(posedge clk_50m) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            frameDone_q <= 1'b0;
            data_q      <= 8'h00;
            lowByte_q   <= 8'h00;
            underrun_q  <= 1'b0;
            syncErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            vsync_q     <= (state_q == S_VSYNC);
            href_q      <= (state_q == S_ACTIVE);
            frameDone_q <= frameEnd;
            data_q      <= data_d;
            lowByte_q   <= lowByte_d;
            underrun_q  <= underrun_d;
            syncErr_q   <= syncErr_d;
        end
    end

    assign dvp_vsync  = vsync_q;
    assign dvp_href   = href_q;
    assign dvp_data   = data_q;
    assign frame_done = frameDone_q;
    assign underrun   = underrun_q;
    assign sync_err   = syncErr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// ============================================================================
// tb_ov5640_dvp_tx
// ----------------------------------------------------------------------------
// Self-checking bench for ov5640_dvp_tx with a small frame geometry
// (4 pixels x 2 lines, 11-cycle lines, 55-cycle frames). A frame-position
// reference model predicts every output on every cycle; a scenario table and
// a few hand-written sequences check the framing corner cases.
// ============================================================================
module tb_ov5640_dvp_tx;

    localparam int HA = 4;
    localparam int HB = 3;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VA = 2;
    localparam int VF = 1;
    localparam int LINE_LEN  = 2 * HA + HB;
    localparam int FRAME_LEN = LINE_LEN * (VS + VB + VA + VF);
    localparam logic [15:0] FILLV = 16'h0000;

    logic        clk_50m = 1'b0;
    logic        sys_rst = 1'b1;
    logic        tx_en = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_ready;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        frame_done;
    logic        underrun;
    logic        sync_err;
    logic        busy;

    ov5640_dvp_tx #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_SYNC   (VS),
        .V_BACK   (VB),
        .V_ACTIVE (VA),
        .V_FRONT  (VF),
        .FILL     (FILLV)
    ) dut (
        .clk_50m    (clk_50m),
        .sys_rst    (sys_rst),
        .tx_en      (tx_en),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .dvp_vsync  (dvp_vsync),
        .dvp_href   (dvp_href),
        .dvp_data   (dvp_data),
        .frame_done (frame_done),
        .underrun   (underrun),
        .sync_err   (sync_err),
        .busy       (busy)
    );

    always #5 clk_50m = ~clk_50m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: whether a frame is running and the cycle position in
    // it; outputs are derived from line = pos / LINE_LEN, col = pos % LINE_LEN.
    bit        mRun = 1'b0;
    int        mPos = 0;
    bit        mUnder = 1'b0;
    bit        mSync = 1'b0;
    logic [7:0] mLow = 8'h00;
    bit        eVs = 1'b0;
    bit        eHref = 1'b0;
    bit        eFd = 1'b0;
    logic [7:0] eData = 8'h00;

    logic [16:0] srcQ[$];
    logic [7:0]  capQ[$];

    typedef struct {
        int         dropSlot;
        int         stale;
        int         sofAt;
        bit         firstSof;
        bit         expUnder;
        bit         expSync;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b4;
        logic [7:0] b6;
    } scen_t;

    scen_t tbl[5];

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Predicted pix_ready for the current position and driven inputs.
    function automatic bit modelReady();
        int line;
        int col;
        if (!mRun) return 1'b0;
        line = mPos / LINE_LEN;
        col  = mPos % LINE_LEN;
        if (line < VS + VB) return pix_valid & ~pix_sof;
        if (line < VS + VB + VA && col < 2 * HA) return (col % 2) == 0;
        return 1'b0;
    endfunction

    // Advance the model across one clock edge using the inputs at that edge.
    task automatic modelStep();
        int line;
        int col;
        eVs = 1'b0; eHref = 1'b0; eFd = 1'b0; eData = 8'h00;
        if (sys_rst) begin
            mRun = 1'b0; mUnder = 1'b0; mSync = 1'b0;
            return;
        end
        if (!mRun) begin
            if (tx_en) begin
                mRun = 1'b1; mPos = 0; mUnder = 1'b0; mSync = 1'b0;
            end
            return;
        end
        line = mPos / LINE_LEN;
        col  = mPos % LINE_LEN;
        if (line < VS) eVs = 1'b1;
        if (line >= VS + VB && line < VS + VB + VA && col < 2 * HA) begin
            eHref = 1'b1;
            if (col % 2 == 0) begin
                if (pix_valid) begin
                    eData = pix_data[15:8];
                    mLow  = pix_data[7:0];
                    if (pix_sof != (line == VS + VB && col == 0)) mSync = 1'b1;
                end else begin
                    eData  = FILLV[15:8];
                    mLow   = FILLV[7:0];
                    mUnder = 1'b1;
                end
            end else begin
                eData = mLow;
            end
        end
        if (mPos == FRAME_LEN - 1) begin
            eFd = 1'b1;
            if (tx_en) mPos = 0;
            else mRun = 1'b0;
        end else begin
            mPos++;
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check pix_ready,
    // clock, then check every registered output at the next falling edge.
    task automatic applyStimulus(input bit rst, input bit txEn, input bit gate);
        bit took;
        sys_rst = rst;
        tx_en   = txEn;
        if (gate && srcQ.size() > 0) begin
            pix_valid = 1'b1;
            pix_data  = srcQ[0][15:0];
            pix_sof   = srcQ[0][16];
        end else begin
            pix_valid = 1'b0;
            pix_data  = 16'($urandom);
            pix_sof   = 1'($urandom);
        end
        #1;
        checkOutput("pix_ready", 32'(pix_ready), 32'(modelReady()));
        took = pix_valid & pix_ready;
        @(posedge clk_50m);
        modelStep();
        if (took) void'(srcQ.pop_front());
        cyc++;
        @(negedge clk_50m);
        checkOutput("dvp_vsync", 32'(dvp_vsync), 32'(eVs));
        checkOutput("dvp_href", 32'(dvp_href), 32'(eHref));
        checkOutput("dvp_data", 32'(dvp_data), 32'(eData));
        checkOutput("frame_done", 32'(frame_done), 32'(eFd));
        checkOutput("underrun", 32'(underrun), 32'(mUnder));
        checkOutput("sync_err", 32'(sync_err), 32'(mSync));
        checkOutput("busy", 32'(busy), 32'(mRun));
        if (dvp_href) capQ.push_back(dvp_data);
    endtask

    task automatic applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] capAt(int i);
        if (i < capQ.size()) return capQ[i];
        return 8'hEE;
    endfunction

    // Queue one 8-pixel frame of 0xA1B2, 0xA2B3, ... with configurable SOF flags.
    task automatic pushFrame(input bit firstSof, input int sofAt);
        for (int k = 0; k < HA * VA; k++) begin
            srcQ.push_back({(k == 0 && firstSof) || (k == sofAt), 16'(16'hA1B2 + k * 16'h0101)});
        end
    endtask

    // Run one frame from IDLE with tx_en dropped right after the start, then
    // compare the sticky flags and selected bytes with the table entry.
    task automatic runFrame(input scen_t s);
        bit pushed;
        bit done;
        bit gate;
        srcQ.delete();
        capQ.delete();
        pushed = 1'b0;
        done = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int t = 0; t < FRAME_LEN + 10 && !done; t++) begin
            if (!pushed && mRun && mPos == VS * LINE_LEN) begin
                for (int i = 0; i < s.stale; i++) srcQ.push_back({1'b0, 16'(16'h5555 + i)});
                pushFrame(s.firstSof, s.sofAt);
                pushed = 1'b1;
            end
            gate = !(s.dropSlot >= 0 && mRun && mPos == (VS + VB) * LINE_LEN + 2 * s.dropSlot);
            applyStimulus(1'b0, 1'b0, gate);
            done = frame_done;
        end
        checkOutput("frame_done_seen", 32'(done), 32'd1);
        checkOutput("tbl_underrun", 32'(underrun), 32'(s.expUnder));
        checkOutput("tbl_sync_err", 32'(sync_err), 32'(s.expSync));
        checkOutput("tbl_bytes", 32'(capQ.size()), 32'(2 * HA * VA));
        checkOutput("tbl_byte0", 32'(capAt(0)), 32'(s.b0));
        checkOutput("tbl_byte1", 32'(capAt(1)), 32'(s.b1));
        checkOutput("tbl_byte4", 32'(capAt(4)), 32'(s.b4));
        checkOutput("tbl_byte6", 32'(capAt(6)), 32'(s.b6));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int e;
        int firstVs;
        int vsCount;
        int hrefCount;
        int fdEdge;
        int vsAt56;
        bit gate;

        tbl[0] = '{-1, 0, -1, 1'b1, 1'b0, 1'b0, 8'hA1, 8'hB2, 8'hA3, 8'hA4};
        tbl[1] = '{ 2, 0, -1, 1'b1, 1'b1, 1'b0, 8'hA1, 8'hB2, 8'h00, 8'hA3};
        tbl[2] = '{-1, 3, -1, 1'b1, 1'b0, 1'b0, 8'hA1, 8'hB2, 8'hA3, 8'hA4};
        tbl[3] = '{-1, 0,  5, 1'b1, 1'b0, 1'b1, 8'hA1, 8'hB2, 8'hA3, 8'hA4};
        tbl[4] = '{-1, 0, -1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};

        @(posedge clk_50m);
        @(negedge clk_50m);
        applyReset();
        checkOutput("reset_vsync", 32'(dvp_vsync), 32'd0);
        checkOutput("reset_data", 32'(dvp_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        // Continuous framing: vsync edges 1..11, frame_done at 55, vsync at 56.
        srcQ.delete();
        capQ.delete();
        pushFrame(1'b1, -1);
        pushFrame(1'b1, -1);
        base = cyc;
        firstVs = -1; vsCount = 0; hrefCount = 0; fdEdge = -1; vsAt56 = 0;
        for (int t = 0; t < 58; t++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            e = cyc - base - 1;
            if (dvp_vsync && firstVs < 0) firstVs = e;
            if (dvp_vsync && e <= 55) vsCount++;
            if (dvp_href && e <= 55) hrefCount++;
            if (frame_done && fdEdge < 0) fdEdge = e;
            if (e == 56) vsAt56 = 32'(dvp_vsync);
        end
        checkOutput("seq_first_vsync", 32'(firstVs), 32'd1);
        checkOutput("seq_vsync_len", 32'(vsCount), 32'(LINE_LEN));
        checkOutput("seq_href_len", 32'(hrefCount), 32'(2 * HA * VA));
        checkOutput("seq_frame_done", 32'(fdEdge), 32'd55);
        checkOutput("seq_vsync_again", 32'(vsAt56), 32'd1);
        checkOutput("seq_byte0", 32'(capAt(0)), 32'hA1);
        checkOutput("seq_byte1", 32'(capAt(1)), 32'hB2);

        // Scenario table: tx_en dropped mid-frame, underrun slot, stale
        // pixels, stray SOF, and a frame whose pixels carry no SOF at all.
        for (int i = 0; i < 5; i++) begin
            applyReset();
            runFrame(tbl[i]);
        end

        // sync_err stays set in IDLE and clears on the next IDLE->VSYNC.
        applyReset();
        runFrame(tbl[3]);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("sticky_in_idle", 32'(sync_err), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("sticky_cleared", 32'(sync_err), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);

        // Reset pulsed in the active region, then a clean frame.
        applyReset();
        srcQ.delete();
        pushFrame(1'b1, -1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int t = 0; t < FRAME_LEN && !(mRun && mPos == (VS + VB) * LINE_LEN + 3); t++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
        checkOutput("pre_reset_href", 32'(dvp_href), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("rst_vsync", 32'(dvp_vsync), 32'd0);
        checkOutput("rst_href", 32'(dvp_href), 32'd0);
        checkOutput("rst_data", 32'(dvp_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(pix_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        runFrame(tbl[0]);

        // Randomised traffic: gappy source, occasional stray SOF, random
        // tx_en and rare resets, all checked by the reference model.
        applyReset();
        srcQ.delete();
        for (int t = 0; t < 700; t++) begin
            if (srcQ.size() < 4) begin
                for (int k = 0; k < HA * VA; k++) begin
                    srcQ.push_back({(k == 0) || ($urandom_range(0, 15) == 0), 16'($urandom)});
                end
            end
            gate = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, gate);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
